// File: rtl/leaf_out_arbiter.sv
// Round-robin arbiter merging several user output streams onto one BFT output link.
// Each port owns a destination table entry, a wrapping BRAM address counter and a freespace credit.
module leaf_out_arbiter #(
  parameter int NUM_OUT_PORTS = 3,
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_ADDR_BITS = 7,
  parameter int PACKET_BITS   = 1 + 5 + 4 + NUM_ADDR_BITS + PAYLOAD_BITS,
  parameter int CREDIT_INIT   = 64
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface,
  input  logic [NUM_OUT_PORTS-1:0]              vld_user2interface,
  output logic [NUM_OUT_PORTS-1:0]              ack_interface2user,
  input  logic                                  cfg_wr,
  input  logic [1:0]                            cfg_port,
  input  logic [4:0]                            cfg_leaf,
  input  logic [3:0]                            cfg_dport,
  input  logic                                  credit_vld,
  input  logic [1:0]                            credit_port,
  input  logic [NUM_ADDR_BITS:0]                credit_amt,
  output logic [PACKET_BITS-1:0]                dout_leaf_interface2bft,
  input  logic                                  bft_ready
);

  localparam int PTR_W = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
  localparam int CW    = NUM_ADDR_BITS + 1;
  localparam logic [CW:0]   CREDIT_MAX = {1'b0, 1'b1, {NUM_ADDR_BITS{1'b0}}};
  localparam logic [CW-1:0] CREDIT_RST = CW'(CREDIT_INIT);

  logic [NUM_OUT_PORTS-1:0] cfg_valid;
  logic [4:0]               leaf     [NUM_OUT_PORTS];
  logic [3:0]               dport    [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] addr_cnt [NUM_OUT_PORTS];
  logic [CW-1:0]            credit   [NUM_OUT_PORTS];
  logic [PTR_W-1:0]         rr_ptr;

  logic                     slot_free;
  logic                     any_gnt;
  logic [NUM_OUT_PORTS-1:0] elig;
  logic [NUM_OUT_PORTS-1:0] gnt;
  logic [PTR_W-1:0]         gnt_idx;
  logic [PTR_W-1:0]         rr_next;
  logic [PACKET_BITS-1:0]   gnt_pkt;
  logic [CW:0]              credit_sum [NUM_OUT_PORTS];
  logic [CW-1:0]            credit_nxt [NUM_OUT_PORTS];

  always_comb begin
    slot_free = ~dout_leaf_interface2bft[PACKET_BITS-1] | bft_ready;
    elig      = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++)
      elig[i] = vld_user2interface[i] & cfg_valid[i] & (credit[i] != '0);

    // Two passes: ports at or above rr_ptr first, then wrap to the low ports.
    any_gnt = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++)
      if (!any_gnt && elig[i] && i >= int'(rr_ptr)) begin
        any_gnt = 1'b1;
        gnt_idx = PTR_W'(i);
      end
    for (int i = 0; i < NUM_OUT_PORTS; i++)
      if (!any_gnt && elig[i]) begin
        any_gnt = 1'b1;
        gnt_idx = PTR_W'(i);
      end
    if (reset || !slot_free)
      any_gnt = 1'b0;

    gnt     = '0;
    gnt_pkt = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++)
      if (any_gnt && gnt_idx == PTR_W'(i)) begin
        gnt[i]  = 1'b1;
        gnt_pkt = {1'b1, leaf[i], dport[i], addr_cnt[i],
                   din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS]};
      end
    rr_next = (int'(gnt_idx) == NUM_OUT_PORTS - 1) ? '0 : gnt_idx + 1'b1;

    // A granted port always holds at least one credit, so the subtraction cannot underflow.
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      credit_sum[i] = {1'b0, credit[i]}
                    + ((credit_vld && int'(credit_port) == i) ? {1'b0, credit_amt} : '0)
                    - {{CW{1'b0}}, gnt[i]};
      credit_nxt[i] = (credit_sum[i] > CREDIT_MAX) ? CREDIT_MAX[CW-1:0] : credit_sum[i][CW-1:0];
    end
  end

  assign ack_interface2user = gnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      dout_leaf_interface2bft <= '0;
      rr_ptr                  <= '0;
      cfg_valid               <= '0;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        leaf[i]     <= '0;
        dport[i]    <= '0;
        addr_cnt[i] <= '0;
        credit[i]   <= CREDIT_RST;
      end
    end else begin
      if (slot_free) begin
        if (any_gnt) begin
          dout_leaf_interface2bft <= gnt_pkt;
          rr_ptr                  <= rr_next;
        end else begin
          dout_leaf_interface2bft[PACKET_BITS-1] <= 1'b0;
        end
      end
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        // A table write wins over the address increment of a same-cycle grant.
        if (cfg_wr && int'(cfg_port) == i) begin
          cfg_valid[i] <= 1'b1;
          leaf[i]      <= cfg_leaf;
          dport[i]     <= cfg_dport;
          addr_cnt[i]  <= '0;
        end else if (gnt[i]) begin
          addr_cnt[i]  <= addr_cnt[i] + 1'b1;
        end
        credit[i] <= credit_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Directed and randomized bench for leaf_out_arbiter against a queue-free behavioural model
// of the destination tables, credits and round-robin pointer.
module tb_leaf_out_arbiter;
  localparam int N     = 3;
  localparam int P     = 32;
  localparam int A     = 7;
  localparam int PB    = 49;
  localparam int CMAX  = 128;
  localparam int CINIT = 64;

  logic            clk = 1'b0;
  logic            reset;
  logic [N*P-1:0]  din;
  logic [N-1:0]    vld;
  logic [N-1:0]    ack;
  logic            cfg_wr;
  logic [1:0]      cfg_port;
  logic [4:0]      cfg_leaf;
  logic [3:0]      cfg_dport;
  logic            credit_vld;
  logic [1:0]      credit_port;
  logic [A:0]      credit_amt;
  logic [PB-1:0]   dout;
  logic            bft_ready;

  always #5 clk = ~clk;

  leaf_out_arbiter dut (
    .clk                     (clk),
    .reset                   (reset),
    .din_leaf_user2interface (din),
    .vld_user2interface      (vld),
    .ack_interface2user      (ack),
    .cfg_wr                  (cfg_wr),
    .cfg_port                (cfg_port),
    .cfg_leaf                (cfg_leaf),
    .cfg_dport               (cfg_dport),
    .credit_vld              (credit_vld),
    .credit_port             (credit_port),
    .credit_amt              (credit_amt),
    .dout_leaf_interface2bft (dout),
    .bft_ready               (bft_ready)
  );

  int passed = 0;
  int total  = 0;

  bit            m_cfg    [N];
  int            m_leaf   [N];
  int            m_dport  [N];
  int            m_addr   [N];
  int            m_credit [N];
  int            m_rr;
  logic [PB-1:0] m_dout = '0;
  int            acks_seen [N];
  int            base;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_dout = '0;
    m_rr   = 0;
    for (int i = 0; i < N; i++) begin
      m_cfg[i] = 1'b0; m_leaf[i] = 0; m_dport[i] = 0; m_addr[i] = 0; m_credit[i] = CINIT;
    end
  endtask

  // One clock: check ack before the edge, advance the model, check dout after it.
  task automatic step();
    int g;
    bit free;
    logic [N-1:0] exp_ack;
    #1;
    free = !m_dout[PB-1] || bft_ready;
    g = -1;
    if (!reset && free)
      for (int k = 0; k < N; k++) begin
        int p;
        p = (m_rr + k) % N;
        if (g < 0 && vld[p] && m_cfg[p] && m_credit[p] > 0) g = p;
      end
    exp_ack = '0;
    if (g >= 0) exp_ack[g] = 1'b1;
    check("ack", 64'(ack), 64'(exp_ack));
    for (int i = 0; i < N; i++) if (ack[i] === 1'b1) acks_seen[i]++;
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      if (free) begin
        if (g >= 0) begin
          m_dout = {1'b1, 5'(m_leaf[g]), 4'(m_dport[g]), 7'(m_addr[g]), din[g*P +: P]};
          m_addr[g] = (m_addr[g] + 1) % 128;
          m_credit[g] = m_credit[g] - 1;
          m_rr = (g + 1) % N;
        end else begin
          m_dout[PB-1] = 1'b0;
        end
      end
      if (credit_vld && int'(credit_port) < N) begin
        m_credit[credit_port] = m_credit[credit_port] + int'(credit_amt);
        if (m_credit[credit_port] > CMAX) m_credit[credit_port] = CMAX;
      end
      if (cfg_wr && int'(cfg_port) < N) begin
        m_cfg[cfg_port]   = 1'b1;
        m_leaf[cfg_port]  = int'(cfg_leaf);
        m_dport[cfg_port] = int'(cfg_dport);
        m_addr[cfg_port]  = 0;
      end
    end
    #1;
    if (m_dout[PB-1]) check("dout", 64'(dout), 64'(m_dout));
    else              check("dout_vld", 64'(dout[PB-1]), 64'(0));
  endtask

  task automatic cfg_step(input int port, input int lf, input int dp);
    cfg_wr = 1'b1; cfg_port = 2'(port); cfg_leaf = 5'(lf); cfg_dport = 4'(dp);
    step();
    cfg_wr = 1'b0;
  endtask

  task automatic credit_step(input int port, input int amt);
    credit_vld = 1'b1; credit_port = 2'(port); credit_amt = 8'(amt);
    step();
    credit_vld = 1'b0;
  endtask

  task automatic rand_din();
    for (int i = 0; i < N; i++) din[i*P +: P] = $urandom;
  endtask

  initial begin
    for (int i = 0; i < N; i++) acks_seen[i] = 0;
    model_reset();
    reset = 1'b1; din = '0; vld = '1; cfg_wr = 1'b0; cfg_port = '0; cfg_leaf = '0;
    cfg_dport = '0; credit_vld = 1'b0; credit_port = '0; credit_amt = '0; bft_ready = 1'b1;
    step(); step();
    check("rst_dout", 64'(dout), 64'(0));
    reset = 1'b0;

    vld = '0;
    for (int p = 0; p < N; p++) cfg_step(p, 3, p + 1);
    vld = '1;
    repeat (9) begin rand_din(); step(); end

    bft_ready = 1'b0;
    repeat (5) begin rand_din(); step(); end
    bft_ready = 1'b1;
    repeat (2) begin rand_din(); step(); end

    cfg_wr = 1'b1; cfg_port = 2'(m_rr); cfg_leaf = 5'd9; cfg_dport = 4'd7;
    rand_din(); step();
    cfg_wr = 1'b0;
    repeat (4) begin rand_din(); step(); end

    bft_ready = 1'b0; step();
    reset = 1'b1; step();
    check("rst_stall_dout", 64'(dout), 64'(0));
    reset = 1'b0; bft_ready = 1'b1;

    vld = '0;
    cfg_step(0, 1, 1);
    cfg_step(2, 2, 2);
    vld = '1;
    base = acks_seen[1];
    repeat (12) begin rand_din(); step(); end
    check("unconf_acks", 64'(acks_seen[1] - base), 64'(0));

    reset = 1'b1; step(); reset = 1'b0;
    vld = '0;
    cfg_step(0, 5, 2);
    vld = 3'b001;
    base = acks_seen[0];
    repeat (70) begin rand_din(); step(); end
    check("credit_exhaust", 64'(acks_seen[0] - base), 64'(64));
    credit_step(0, 64);
    repeat (70) begin rand_din(); step(); end
    check("credit_return", 64'(acks_seen[0] - base), 64'(128));
    vld = '0;
    credit_step(0, 127);
    credit_step(0, 10);
    vld = 3'b001;
    repeat (135) begin rand_din(); step(); end
    check("credit_sat", 64'(acks_seen[0] - base), 64'(256));
    vld = '0;
    credit_step(0, 1);
    vld = 3'b001;
    credit_step(0, 5);
    repeat (10) begin rand_din(); step(); end
    check("credit_grant_ret", 64'(acks_seen[0] - base), 64'(262));

    for (int p = 0; p < N; p++) cfg_step(p, p + 4, p + 8);
    repeat (1500) begin
      rand_din();
      vld         = 3'($urandom);
      bft_ready   = ($urandom % 4) != 0;
      cfg_wr      = ($urandom % 16) == 0;
      cfg_port    = 2'($urandom);
      cfg_leaf    = 5'($urandom);
      cfg_dport   = 4'($urandom);
      credit_vld  = ($urandom % 6) == 0;
      credit_port = 2'($urandom);
      credit_amt  = 8'($urandom % 40);
      reset       = ($urandom % 400) == 0;
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
